// File: rtl/abs_sub_inverse_pkg.sv
// Shared constants and result type for the abs_sub_inverse block.
// Optional statistics counter is enabled by defining ABS_SUB_INVERSE_STATS_EN.
package abs_sub_inverse_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int ERR_CNT_W     = 16;

  // `unique` is a reserved word, so the d==0 flag is carried as is_unique.
  typedef struct packed {
    logic [DEFAULT_WIDTH-1:0] cand_lo;
    logic [DEFAULT_WIDTH-1:0] cand_hi;
    logic                     lo_ok;
    logic                     hi_ok;
    logic                     is_unique;
    logic                     inconsistent;
  } result_t;

endpackage

// File: rtl/abs_sub_inverse_if.sv
// Ready/valid bus for abs_sub_inverse: score/ref_op pairs in, candidates and flags out.
interface abs_sub_inverse_if
  import abs_sub_inverse_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] score;
  logic [WIDTH-1:0] ref_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] cand_lo;
  logic [WIDTH-1:0] cand_hi;
  logic             lo_ok;
  logic             hi_ok;
  logic             is_unique;
  logic             inconsistent;

  modport master (
    output in_valid, score, ref_op, out_ready,
    input  in_ready, out_valid, cand_lo, cand_hi, lo_ok, hi_ok, is_unique, inconsistent
  );

  modport slave (
    input  in_valid, score, ref_op, out_ready,
    output in_ready, out_valid, cand_lo, cand_hi, lo_ok, hi_ok, is_unique, inconsistent
  );
endinterface

// File: rtl/abs_sub_inverse_calc.sv
// Combinational recovery of the two candidates b = ref_op -/+ d and their validity flags.
module abs_sub_inverse_calc
  import abs_sub_inverse_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] ref_op,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] cand_lo,
  output logic [WIDTH-1:0] cand_hi,
  output logic             lo_ok,
  output logic             hi_ok,
  output logic             is_unique,
  output logic             inconsistent
);
  logic [WIDTH:0] sum;

  // The extra sum bit is the carry that marks ref_op+d as out of range.
  assign sum          = {1'b0, ref_op} + {1'b0, d};
  assign cand_hi      = sum[WIDTH-1:0];
  assign hi_ok        = ~sum[WIDTH];
  assign lo_ok        = (ref_op >= d);
  assign cand_lo      = ref_op - d;
  assign is_unique    = (d == '0);
  assign inconsistent = ~lo_ok & ~hi_ok;
endmodule

// File: rtl/abs_sub_inverse.sv
// Two-stage elastic pipeline inverting score = MAX - |a-b| for b, given a = ref_op.
// Defining ABS_SUB_INVERSE_STATS_EN adds stats_clr / err_cnt (inconsistent-result counter).
module abs_sub_inverse
  import abs_sub_inverse_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
`ifdef ABS_SUB_INVERSE_STATS_EN
  input  logic                 stats_clr,
  output logic [ERR_CNT_W-1:0] err_cnt,
`endif
  abs_sub_inverse_if.slave     bus
);
  localparam logic [WIDTH-1:0] MAX_VAL = '1;

  logic             s1_valid, s2_valid;
  logic             s1_load, s2_load;
  logic [WIDTH-1:0] s1_ref, s1_d;

  logic [WIDTH-1:0] c_lo, c_hi;
  logic             c_lo_ok, c_hi_ok, c_unique, c_incons;

  logic [WIDTH-1:0] s2_lo, s2_hi;
  logic             s2_lo_ok, s2_hi_ok, s2_unique, s2_incons;

  assign s2_load      = ~s2_valid | bus.out_ready;
  assign s1_load      = ~s1_valid | s2_load;
  assign bus.in_ready = s1_load;

  // NOTE: data registers are reset along with valids so every output reads zero after reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_ref   <= '0;
      s1_d     <= '0;
    end else if (s1_load) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_ref <= bus.ref_op;
        s1_d   <= MAX_VAL - bus.score;
      end
    end
  end

  abs_sub_inverse_calc #(.WIDTH(WIDTH)) u_calc (
    .ref_op       (s1_ref),
    .d            (s1_d),
    .cand_lo      (c_lo),
    .cand_hi      (c_hi),
    .lo_ok        (c_lo_ok),
    .hi_ok        (c_hi_ok),
    .is_unique    (c_unique),
    .inconsistent (c_incons)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      s2_valid  <= 1'b0;
      s2_lo     <= '0;
      s2_hi     <= '0;
      s2_lo_ok  <= 1'b0;
      s2_hi_ok  <= 1'b0;
      s2_unique <= 1'b0;
      s2_incons <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_lo     <= c_lo;
        s2_hi     <= c_hi;
        s2_lo_ok  <= c_lo_ok;
        s2_hi_ok  <= c_hi_ok;
        s2_unique <= c_unique;
        s2_incons <= c_incons;
      end
    end
  end

  assign bus.out_valid    = s2_valid;
  assign bus.cand_lo      = s2_lo;
  assign bus.cand_hi      = s2_hi;
  assign bus.lo_ok        = s2_lo_ok;
  assign bus.hi_ok        = s2_hi_ok;
  assign bus.is_unique    = s2_unique;
  assign bus.inconsistent = s2_incons;

`ifdef ABS_SUB_INVERSE_STATS_EN
  // Clear has priority over a same-cycle increment; the count saturates at all ones.
  always_ff @(posedge clk) begin
    if (!rst || stats_clr) begin
      err_cnt <= '0;
    end else if (s2_valid && bus.out_ready && s2_incons && (err_cnt != '1)) begin
      err_cnt <= err_cnt + ERR_CNT_W'(1);
    end
  end
`endif
endmodule

// File: doc/abs_sub_inverse.md
ABS_SUB_INVERSE -- requirements
Module: abs_sub_inverse

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand/score width; MAX = 2^WIDTH-1.
REQ-002 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  score/ref_op pair offered.
REQ-005 SHALL have port in_ready  output  1  block accepts a pair this cycle.
REQ-006 SHALL have port score  input  WIDTH  similarity score, MAX - |a-b|.
REQ-007 SHALL have port ref_op  input  WIDTH  known operand a.
REQ-008 SHALL have port out_valid  output  1  result held on outputs.
REQ-009 SHALL have port out_ready  input  1  consumer takes result.
REQ-010 SHALL have ports cand_lo and cand_hi  output  WIDTH  candidates ref_op-d and ref_op+d, with d = MAX - score.
REQ-011 SHALL have ports lo_ok, hi_ok, unique, inconsistent  output  1  candidate-valid flags, d==0 flag, no-solution flag.

Function
REQ-012 SHALL compute d = MAX - score, WIDTH bits, no overflow possible.
REQ-013 SHALL set lo_ok = (ref_op >= d) and cand_lo = ref_op - d, truncated to WIDTH bits.
REQ-014 SHALL set hi_ok = no carry out of ref_op + d, and cand_hi = (ref_op + d) truncated to WIDTH bits.
REQ-015 SHALL, when d == 0: unique=1, lo_ok=hi_ok=1, cand_lo=cand_hi=ref_op.
REQ-016 SHALL set inconsistent = !lo_ok && !hi_ok; candidates still driven with truncated values.
REQ-017 SHALL be a 2-stage elastic pipeline: stage 1 registers ref_op and d; stage 2 registers candidates and flags.
REQ-018 SHALL have latency 2 cycles from accept (in_valid && in_ready) to out_valid with out_ready held high, at throughput 1 pair/cycle.
REQ-019 SHALL load stage 2 when !s2_valid || out_ready.
REQ-020 SHALL load stage 1 when !s1_valid || stage-2 load.
REQ-021 SHALL drive in_ready = !s1_valid || stage-2 load; a combinational path from out_ready is permitted.
REQ-022 SHALL keep out_valid and all outputs stable while out_valid && !out_ready; SHALL drop, duplicate or reorder no result.
REQ-023 SHALL clear a stage's valid when it is consumed with no new data loaded into it.

Reset
REQ-024 SHALL, on rising clk with rst==0: s1_valid=s2_valid=out_valid=0; cand_lo, cand_hi, all flags and stage data = 0.
REQ-025 SHALL drive in_ready=1 in the first cycle after rst deasserts.
REQ-026 SHALL discard in-flight pairs on reset mid-operation; none appears afterwards.
REQ-027 SHALL ignore in_valid while rst==0.

Configuration
REQ-028 SHALL, with macro ABS_SUB_INVERSE_STATS_EN defined, add input stats_clr (1) and output err_cnt (16).
REQ-029 SHALL, under that macro, increment err_cnt by 1 per result transferred (out_valid && out_ready) with inconsistent=1, saturating at 16'hFFFF.
REQ-030 SHALL, under that macro, make stats_clr set err_cnt to 0 on the next edge, with clear winning over a simultaneous increment; reset SHALL also set err_cnt to 0.
REQ-031 SHALL, without the macro, have neither port nor counter, and all other behaviour SHALL be identical.

Structure
REQ-032 SHALL place in the shared package: the default WIDTH constant, the err_cnt width constant (16), and a packed result typedef {cand_lo, cand_hi, lo_ok, hi_ok, unique, inconsistent}.
REQ-033 SHALL put the combinational candidate/flag computation in sub-module abs_sub_inverse_calc, instantiated once between stage 1 and stage 2.

Verification (WIDTH=8, out_ready=1 unless stated)
REQ-034 SHALL check: score=255, ref_op=37 -> 2 cycles later cand_lo=cand_hi=37, lo_ok=hi_ok=1, unique=1, inconsistent=0.
REQ-035 SHALL check: score=250, ref_op=3 -> cand_hi=8, hi_ok=1, lo_ok=0 (cand_lo=254), unique=0.
REQ-036 SHALL check: score=250, ref_op=253 -> cand_lo=248, lo_ok=1, hi_ok=0 (cand_hi=2).
REQ-037 SHALL check: score=55, ref_op=100 (d=200) -> inconsistent=1; with the STATS macro, err_cnt goes 0->1 on transfer, and stats_clr asserted in the same cycle -> err_cnt=0.
REQ-038 SHALL check: 4 back-to-back pairs, out_ready=0 for cycles 3-5 -> in_ready=0 while both stages full, 4 results in order, each held stable while stalled.
REQ-039 SHALL check: rst=0 for one cycle with 2 pairs in flight -> out_valid=0 next cycle, no stale result emitted, in_ready=1 after release.
